// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the EX stage: multi-cycle mult/div with a fixed latency,
// single-cycle mthi/mtlo, and a registered busy flag that feeds the hazard unit's stall.
module mul_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpRsvd  = 3'd7
  } op_e;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q;
  op_e             op_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q, b_q;
  logic            busy_q;
  logic [31:0]     hi_q, lo_q;

  // Results are formed combinationally from the latched operands and written at completion.
  logic        is_mul, is_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, quot_mag, rem_mag, quot, rem;

  always_comb begin
    is_mul    = (op_q == OpMult) || (op_q == OpMultu);
    is_signed = (op_q == OpMult) || (op_q == OpDiv);
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    ext_a     = {{32{is_signed & a_q[31]}}, a_q};
    ext_b     = {{32{is_signed & b_q[31]}}, b_q};
    prod      = ext_a * ext_b;
    neg_a     = is_signed & a_q[31];
    neg_b     = is_signed & b_q[31];
    mag_a     = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b     = neg_b ? (~b_q + 32'd1) : b_q;
    quot_mag  = '0;
    rem_mag   = '0;
    if (mag_b != '0) begin
      quot_mag = mag_a / mag_b;
      rem_mag  = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? (~quot_mag + 32'd1) : quot_mag;
    rem  = neg_a ? (~rem_mag + 32'd1) : rem_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op_e'(op))
              OpMult, OpMultu: begin
                a_q     <= srcA;
                b_q     <= srcB;
                op_q    <= op_e'(op);
                cnt_q   <= MulLoad;
                busy_q  <= 1'b1;
                state_q <= StBusy;
              end
              OpDiv, OpDivu: begin
                a_q     <= srcA;
                b_q     <= srcB;
                op_q    <= op_e'(op);
                cnt_q   <= DivLoad;
                busy_q  <= 1'b1;
                state_q <= StBusy;
              end
              OpMthi:  hi_q <= srcA;
              OpMtlo:  lo_q <= srcA;
              default: ;
            endcase
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (is_mul) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (b_q != '0) begin
              // Divide by zero leaves HI/LO untouched.
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
